// File: rtl/sar_comparator_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sar_comparator_ctrl : successive-approximation controller, MSB first     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module sar_comparator_ctrl #(
  parameter int N       = 8,
  parameter int SETTLE  = 1,
  parameter int CMP_CYC = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic         cmp_out,
  output logic         cmp_en,
  output logic [N-1:0] dac_code,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int IW   = $clog2(N);
  localparam int TMAX = (SETTLE > CMP_CYC) ? SETTLE : CMP_CYC;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] c_settle_last = TW'(SETTLE - 1);
  localparam logic [TW-1:0] c_cmp_last    = TW'(CMP_CYC - 1);
  localparam logic [IW-1:0] c_idx_msb     = IW'(N - 1);
  localparam logic [N-1:0]  c_msb_code    = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_COMPARE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [N-1:0]  dac_code_q, dac_code_d;
  logic [N-1:0]  result_q, result_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          cmp_en_q, cmp_en_d;
  logic [N-1:0]  decided;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    timer_d    = timer_q;
    dac_code_d = dac_code_q;
    result_d   = result_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    // Current code with the bit under test replaced by the comparator decision.
    decided          = dac_code_q;
    decided[idx_q]   = cmp_out;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_SETTLE;
          dac_code_d = c_msb_code;
          idx_d      = c_idx_msb;
          timer_d    = '0;
          busy_d     = 1'b1;
        end
      end

      ST_SETTLE: begin
        if (abort) begin
          state_d    = ST_IDLE;
          dac_code_d = '0;
          busy_d     = 1'b0;
          timer_d    = '0;
        end else if (timer_q == c_settle_last) begin
          state_d = ST_COMPARE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      ST_COMPARE: begin
        if (abort) begin
          state_d    = ST_IDLE;
          dac_code_d = '0;
          busy_d     = 1'b0;
          timer_d    = '0;
        end else if (timer_q == c_cmp_last) begin
          timer_d = '0;
          if (idx_q != '0) begin
            dac_code_d                 = decided;
            dac_code_d[idx_q - IW'(1)] = 1'b1;
            idx_d                      = idx_q - IW'(1);
            state_d                    = ST_SETTLE;
          end else begin
            result_d   = decided;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            dac_code_d = '0;
            state_d    = ST_IDLE;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      default: begin
        state_d    = ST_IDLE;
        dac_code_d = '0;
        busy_d     = 1'b0;
        timer_d    = '0;
      end
    endcase

    // Registered strobe keeps the comparator enable free of decode glitches.
    cmp_en_d = (state_d == ST_COMPARE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      timer_q    <= '0;
      dac_code_q <= '0;
      result_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cmp_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      dac_code_q <= dac_code_d;
      result_q   <= result_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cmp_en_q   <= cmp_en_d;
    end
  end

  assign cmp_en   = cmp_en_q;
  assign dac_code = dac_code_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;

endmodule
`default_nettype wire
